// File: rtl/dcim_seq_ctrl.sv
// dcim_seq_ctrl: command sequencer in front of the DCIM macro.
//
// Takes one command at a time over cmd_valid/cmd_ready:
//   op=0 (load)    : writes cmd_len weight rows, one row per w_valid/w_ready
//                    beat, through mac_wen/mac_waddr/mac_wdata.
//   op=1 (compute) : streams cmd_x bit-serially, LSB first, on mac_xbit.
//                    It pulses mac_st with the first bit, waits MAC_LAT
//                    cycles, then captures mac_nout and returns it on
//                    res_valid/res_data, holding it until res_ready.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   cmd_valid/ready/op/len/x       command channel
//   w_valid/ready/data             weight beat channel (active in LOAD only)
//   mac_wen/waddr/wdata            macro row write (registered)
//   mac_st, mac_xbit               macro start strobe, activation bit-plane (registered)
//   mac_nout                       macro result input
//   res_valid/ready/data           result channel (registered)
//   busy                           high whenever the sequencer is not idle
module dcim_seq_ctrl #(
    parameter int ROWS    = 16,
    parameter int AW      = 4,
    parameter int WW      = 8,
    parameter int IN_BITS = 8,
    parameter int MAC_LAT = 2,
    parameter int OW      = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [AW:0]             cmd_len,
    input  logic [ROWS*IN_BITS-1:0] cmd_x,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [WW-1:0]           w_data,
    output logic                    mac_wen,
    output logic [AW-1:0]           mac_waddr,
    output logic [WW-1:0]           mac_wdata,
    output logic                    mac_st,
    output logic [ROWS-1:0]         mac_xbit,
    input  logic [OW-1:0]           mac_nout,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OW-1:0]           res_data,
    output logic                    busy
);

    localparam int KW  = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int WCW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                    state, state_n;
    logic [AW:0]               len_q, row_q;
    logic [KW-1:0]             k_q;
    logic [WCW-1:0]            wcnt_q;
    logic [ROWS*IN_BITS-1:0]   x_q;

    logic cmd_fire, w_fire, len_ok;
    logic load_last, stream_last, wait_last;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign w_fire      = w_valid && w_ready;
    assign len_ok      = (cmd_len != '0) && (cmd_len <= (AW+1)'(ROWS));
    assign load_last   = w_fire && ((row_q + (AW+1)'(1)) == len_q);
    assign stream_last = (k_q == KW'(IN_BITS - 1));
    assign wait_last   = (wcnt_q == WCW'(MAC_LAT - 1));

    assign w_ready = (state == S_LOAD);
    assign busy    = (state != S_IDLE);

    // Next bit-plane to drive. In IDLE this is plane 0 of the incoming
    // command (so mac_xbit is valid together with mac_st); in STREAM it is
    // plane k+1 of the latched activations.
    logic [ROWS-1:0][IN_BITS-1:0] xrows;
    logic [KW-1:0]                ksel;
    logic [ROWS-1:0]              plane_n;

    assign xrows = (state == S_IDLE) ? cmd_x : x_q;
    assign ksel  = (state == S_IDLE) ? '0 : k_q + KW'(1);

    for (genvar r = 0; r < ROWS; r++) begin : g_plane
        assign plane_n[r] = xrows[r][ksel];
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_op)      state_n = S_STREAM;
                    else if (len_ok) state_n = S_LOAD;
                end
            end
            S_LOAD:   if (load_last)   state_n = S_IDLE;
            S_STREAM: if (stream_last) state_n = S_WAIT;
            S_WAIT:   if (wait_last)   state_n = S_OUT;
            S_OUT:    if (res_ready)   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Registered outputs and counters. cmd_ready is registered from the
    // next state so it stays low through reset and rises one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready <= 1'b0;
            mac_wen   <= 1'b0;
            mac_waddr <= '0;
            mac_wdata <= '0;
            mac_st    <= 1'b0;
            mac_xbit  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            len_q     <= '0;
            row_q     <= '0;
            k_q       <= '0;
            wcnt_q    <= '0;
            x_q       <= '0;
        end else begin
            cmd_ready <= (state_n == S_IDLE);
            mac_wen   <= 1'b0;
            mac_st    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_op) begin
                            x_q      <= cmd_x;
                            k_q      <= '0;
                            mac_st   <= 1'b1;
                            mac_xbit <= plane_n;
                        end else if (len_ok) begin
                            len_q <= cmd_len;
                            row_q <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_fire) begin
                        mac_wen   <= 1'b1;
                        mac_waddr <= row_q[AW-1:0];
                        mac_wdata <= w_data;
                        row_q     <= row_q + (AW+1)'(1);
                    end
                end
                S_STREAM: begin
                    if (stream_last) begin
                        mac_xbit <= '0;
                        wcnt_q   <= '0;
                    end else begin
                        mac_xbit <= plane_n;
                        k_q      <= k_q + KW'(1);
                    end
                end
                S_WAIT: begin
                    if (wait_last) begin
                        res_data  <= mac_nout;
                        res_valid <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dcim_seq_ctrl.md
Name: dcim_seq_ctrl

Overview:
Sequencer in front of the DCIM macro. It accepts load and compute commands over a valid/ready interface. Load commands write weight rows into the macro. Compute commands stream activations bit-serially, LSB first, pulse the macro start strobe (st), wait out the macro latency, capture nout, and return it over a valid/ready result port. Only one command is in flight at a time.

Parameters:
ROWS, 16, weight rows in the macro (activation vector length)
AW, 4, row address width, equal to clog2(ROWS)
WW, 8, weight word width
IN_BITS, 8, activation bit width, which is also the number of stream cycles
MAC_LAT, 2, cycles from the last streamed bit to a valid mac_nout (at least 1)
OW, 24, nout / result width

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready (high only in IDLE)
cmd_op  in  1  0 = weight load, 1 = compute
cmd_len  in  AW+1  number of rows to load, legal range 1..ROWS
cmd_x  in  ROWS*IN_BITS  activations; row r occupies bits [r*IN_BITS +: IN_BITS]
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat ready
w_data  in  WW  weight word
mac_wen  out  1  macro row write enable
mac_waddr  out  AW  macro row address
mac_wdata  out  WW  macro write data
mac_st  out  1  macro start strobe (nout/st interface)
mac_xbit  out  ROWS  current activation bit-plane
mac_nout  in  OW  macro result
res_valid  out  1  result valid
res_ready  in  1  result ready
res_data  out  OW  captured nout
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rstn low, asynchronous): state goes to IDLE; every output and counter is 0, including cmd_ready.
  - cmd_ready rises in the first cycle after rstn deasserts.
  - Reset mid-operation abandons the operation immediately. No result is produced and macro contents are not touched.
- All mac_* outputs, res_valid and res_data are registered.
- States: IDLE, LOAD, STREAM, WAIT, OUT.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid && cmd_ready.
  - op=0 with 1<=cmd_len<=ROWS: go to LOAD with row counter 0 and latch len.
  - op=0 with cmd_len=0 or cmd_len>ROWS: command is consumed and dropped; stay in IDLE.
  - op=1: latch cmd_x, go to STREAM with bit counter k=0.
- LOAD:
  - w_ready=1. Each w_valid && w_ready beat produces, next cycle, mac_wen=1, mac_waddr=row counter, mac_wdata=w_data. The row counter then increments.
  - Gaps in w_valid give mac_wen=0 and no progress.
  - After beat number len, return to IDLE. The last mac_wen occurs in the first IDLE cycle.
  - Outside LOAD, w_ready=0 and w_valid is ignored.
- STREAM:
  - Runs for exactly IN_BITS cycles, k=0..IN_BITS-1.
  - mac_xbit[r] = latched x[r*IN_BITS+k].
  - mac_st=1 only for k=0, giving a one-cycle pulse per compute.
  - After the final bit, mac_xbit returns to 0 and the state moves to WAIT.
- WAIT:
  - Counts MAC_LAT cycles.
  - mac_nout is sampled into res_data on the clock edge ending the MAC_LAT-th WAIT cycle, then the state moves to OUT.
- OUT:
  - res_valid=1 and res_data is held stable until res_ready.
  - On handshake: res_valid=0 next cycle, state returns to IDLE.
  - If res_ready is already high on entry, res_valid lasts exactly 1 cycle.
- Compute latency, with the command accepted at edge T:
  - mac_st high in cycle T+1.
  - Bits driven in cycles T+1..T+IN_BITS.
  - nout sampled at edge T+IN_BITS+MAC_LAT.
  - res_valid first high in cycle T+IN_BITS+MAC_LAT+1, which is cycle T+11 for the defaults.
- Back-to-back commands:
  - The next command can be accepted in the first IDLE cycle after a completion.
  - A compute issued right after a load drives its mac_st one cycle after the final mac_wen, so the macro never sees a write and st in the same cycle.
- busy = (state != IDLE).
- No arithmetic is performed on nout; it is passed through at OW bits.

Test Plan:
- Reset release: rstn low for 3 cycles, then high → all outputs 0 during reset; cmd_ready=1 one cycle after release; busy=0.
- Load 16 rows: op=0, len=16, w_data=8'h10+i with no gaps → 16 mac_wen pulses, waddr 0..15, wdata 8'h10..8'h1F; cmd_ready back high after beat 16.
- Load with stalls: len=4, w_valid toggling 1,0,1,1,0,1 → mac_wen pattern tracks the beats, waddr 0..3 contiguous; len=0 is dropped, len=17 is dropped, neither leaves IDLE.
- Compute, all activations 8'hA5: cmd at T → mac_st only at T+1; mac_xbit = all-ones, all-zeros, all-ones, all-zeros, all-zeros, all-ones, all-zeros, all-ones over T+1..T+8 (LSB first); a model mac_nout=24'h00ABCD sampled gives res_valid at T+11 with res_data=24'h00ABCD.
- Result backpressure: res_ready held low for 5 cycles → res_valid and res_data stable and cmd_ready=0 throughout; after the handshake, IDLE and a new compute accepted.
- Reset mid-STREAM at k=3 → mac_st, mac_xbit and res_valid go to 0 immediately; no result emitted; next compute behaves normally.
